seq_detector_prog: RTL and testbench

//  Programmable Moore serial-sequence detector; parametrised successor to the team's fixed 5-bit detector.

---
 rtl/seq_detector_prog_pkg.sv | 11 +
 rtl/seq_match_cmp.sv | 27 ++
 rtl/seq_detector_prog.sv | 109 ++++++++++
 tb/tb_seq_detector_prog.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seq_detector_prog_pkg.sv
// Shared definitions for the programmable serial-sequence detector.
// Holds the FSM state encodings used by seq_detector_prog.
package seq_detector_prog_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;  // no legal pattern loaded
  localparam state_t ST_HUNT  = 2'd1;  // searching the stream
  localparam state_t ST_FOUND = 2'd2;  // match accepted on the previous edge

endpackage

// File: rtl/seq_match_cmp.sv
// Masked pattern compare for seq_detector_prog. Purely combinational.
// Ports:
//   history  in   MAX_LEN  most recent bits, bit 0 = newest
//   pat      in   MAX_LEN  pattern, bit 0 = last bit expected
//   len      in   LEN_W    number of low bits that take part in the compare
//   hit      out  1        low len bits of history equal those of pat
module seq_match_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] history,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    hit = (((history ^ pat) & mask) == '0);
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable Moore serial-sequence detector.
// The pattern, its length and the overlap mode are loaded at run time.
// Ports:
//   clk          in   1        clock, posedge
//   rst          in   1        synchronous active-high reset
//   en           in   1        x is a valid sample this cycle
//   x            in   1        serial data bit
//   cfg_load     in   1        load cfg_pat/cfg_len/cfg_overlap
//   cfg_pat      in   MAX_LEN  pattern, bit cfg_len-1 received first
//   cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//   cfg_overlap  in   1        1 = overlapping matches allowed
//   y            out  1        high while in FOUND
//   match_cnt    out  CNT_W    saturating match count since reset/load
//   armed        out  1        legal pattern loaded, detection active
module seq_detector_prog
  import seq_detector_prog_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // The oldest history bit is only ever needed in the compare of the sample
  // that shifts it out, so the register holds MAX_LEN-1 bits and the
  // compare works on the post-shift view.
  logic [MAX_LEN-2:0] history;
  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   seen;
  logic [LEN_W-1:0]   seen_inc;
  logic               hit;
  logic               match;
  logic               len_legal;

  always_comb begin
    hist_next = {history, x};
    seen_inc  = (seen == LEN_W'(MAX_LEN)) ? seen : seen + LEN_W'(1);
    match     = (seen_inc >= len_q) && hit;
    len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  seq_match_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .history (hist_next),
    .pat     (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      history   <= '0;
      seen      <= '0;
      match_cnt <= '0;
    end else if (cfg_load) begin
      history   <= '0;
      seen      <= '0;
      match_cnt <= '0;
      if (len_legal) begin
        pat_q <= cfg_pat;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        state <= ST_HUNT;
      end else begin
        state <= ST_IDLE;
      end
    end else if (state != ST_IDLE) begin
      if (en) begin
        history <= hist_next[MAX_LEN-2:0];
        if (match) begin
          state <= ST_FOUND;
          seen  <= ovl_q ? seen_inc : '0;
          if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        end else begin
          state <= ST_HUNT;
          seen  <= seen_inc;
        end
      end else begin
        state <= ST_HUNT;
      end
    end
  end

  assign y     = (state == ST_FOUND);
  assign armed = (state != ST_IDLE);

endmodule

// File: tb/tb_seq_detector_prog.sv
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst, en, x, cfg_load, cfg_overlap;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       y_a, armed_a, y_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  seq_detector_prog #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .cfg_load(cfg_load),
    .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .y(y_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  typedef struct {
    logic       rst;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       en;
    logic       x;
    logic       ey;
    logic [7:0] ecnt;
    logic       earm;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, ld, input logic [7:0] pat, input logic [3:0] len,
                     input logic ovl, e, xx, ey, input logic [7:0] ecnt, input logic earm);
    vec_t v;
    v.rst = r; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl;
    v.en = e; v.x = xx; v.ey = ey; v.ecnt = ecnt; v.earm = earm;
    vq.push_back(v);
  endtask

  // sample cycle: en, x, expected y, cnt, armed after the edge
  task automatic s(input logic e, xx, ey, input logic [7:0] ecnt, input logic earm);
    add(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, e, xx, ey, ecnt, earm);
  endtask

  // load cycle with en=0; expected y=0, cnt=0
  task automatic ld(input logic [7:0] pat, input logic [3:0] len, input logic ovl, earm);
    add(1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b0, 1'b0, 8'd0, earm);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s @%0d: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic drive(input logic r, l, input logic [7:0] pat, input logic [3:0] len,
                       input logic ovl, e, xx);
    @(negedge clk);
    rst = r; cfg_load = l; cfg_pat = pat; cfg_len = len; cfg_overlap = ovl; en = e; x = xx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; x = 1'b0; cfg_load = 1'b0;
    cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0;

    // reset state
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    // x ignored while IDLE
    s(1, 1, 0, 0, 0); s(1, 1, 0, 0, 0);

    // 1: 11010, len 5, no overlap; upper pattern bits set but masked
    ld(8'hFA, 4'd5, 1'b0, 1'b1);
    s(1, 1, 0, 0, 1); s(1, 1, 0, 0, 1); s(1, 0, 0, 0, 1); s(1, 1, 0, 0, 1);
    s(1, 0, 1, 1, 1); s(0, 0, 0, 1, 1);

    // 2: 1010 overlapping -> two pulses
    ld(8'h0A, 4'd4, 1'b1, 1'b1);
    s(1, 1, 0, 0, 1); s(1, 0, 0, 0, 1); s(1, 1, 0, 0, 1); s(1, 0, 1, 1, 1);
    s(1, 1, 0, 1, 1); s(1, 0, 1, 2, 1); s(0, 0, 0, 2, 1);
    // 1010 non-overlapping -> one pulse
    ld(8'h0A, 4'd4, 1'b0, 1'b1);
    s(1, 1, 0, 0, 1); s(1, 0, 0, 0, 1); s(1, 1, 0, 0, 1); s(1, 0, 1, 1, 1);
    s(1, 1, 0, 1, 1); s(1, 0, 0, 1, 1); s(0, 0, 0, 1, 1);

    // 3: test 1 with 3-cycle en gaps (x toggling during gaps)
    ld(8'h1A, 4'd5, 1'b0, 1'b1);
    s(1, 1, 0, 0, 1); s(0, 0, 0, 0, 1); s(0, 1, 0, 0, 1); s(0, 0, 0, 0, 1);
    s(1, 1, 0, 0, 1); s(0, 0, 0, 0, 1); s(0, 1, 0, 0, 1); s(0, 0, 0, 0, 1);
    s(1, 0, 0, 0, 1); s(0, 1, 0, 0, 1); s(0, 1, 0, 0, 1); s(0, 0, 0, 0, 1);
    s(1, 1, 0, 0, 1); s(0, 0, 0, 0, 1); s(0, 1, 0, 0, 1); s(0, 0, 0, 0, 1);
    s(1, 0, 1, 1, 1); s(0, 0, 0, 1, 1); s(0, 0, 0, 1, 1); s(0, 0, 0, 1, 1);

    // 4: illegal lengths
    ld(8'h01, 4'd0, 1'b1, 1'b0);
    s(1, 1, 0, 0, 0); s(1, 0, 0, 0, 0); s(1, 1, 0, 0, 0);
    ld(8'h01, 4'd9, 1'b1, 1'b0);
    s(1, 1, 0, 0, 0); s(1, 1, 0, 0, 0); s(1, 0, 0, 0, 0);
    // len 1, eight 1s -> y held high, cnt 1..8
    ld(8'h01, 4'd1, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) s(1, 1, 1, 8'(i), 1);
    s(1, 0, 0, 8, 1);

    // len = MAX_LEN, seen saturates, overlap on all-ones
    ld(8'hFF, 4'd8, 1'b1, 1'b1);
    for (int i = 1; i <= 7; i++) s(1, 1, 0, 0, 1);
    s(1, 1, 1, 1, 1); s(1, 1, 1, 2, 1); s(1, 1, 1, 3, 1); s(1, 0, 0, 3, 1);

    // 5: load with en=1 discards the sample
    add(1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    s(1, 1, 1, 1, 1);

    // 6: rst on the last pattern bit
    ld(8'h1A, 4'd5, 1'b0, 1'b1);
    s(1, 1, 0, 0, 1); s(1, 1, 0, 0, 1); s(1, 0, 0, 0, 1); s(1, 1, 0, 0, 1);
    add(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    // rst beats a simultaneous load
    add(1'b1, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    // load while in FOUND
    ld(8'h01, 4'd1, 1'b1, 1'b1);
    s(1, 1, 1, 1, 1);
    add(1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    s(0, 1, 0, 0, 1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].ld, vq[i].pat, vq[i].len, vq[i].ovl, vq[i].en, vq[i].x);
      check("y", i, int'(y_a), int'(vq[i].ey));
      check("match_cnt", i, int'(cnt_a), int'(vq[i].ecnt));
      check("armed", i, int'(armed_a), int'(vq[i].earm));
    end

    // 5: 2-bit counter saturates at 3 over ten back-to-back matches
    drive(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
    check("b_rst_cnt", 0, int'(cnt_b), 0);
    drive(1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    check("b_armed", 0, int'(armed_b), 1);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
      check("b_y", i, int'(y_b), 1);
      check("b_cnt_sat", i, int'(cnt_b), (i < 3) ? i : 3);
    end
    drive(1'b0, 1'b1, 8'h01, 4'd1, 1'b1, 1'b1, 1'b1);
    check("b_load_cnt", 0, int'(cnt_b), 0);
    check("b_load_y", 0, int'(y_b), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
